cache_control_nway: RTL and testbench

Control FSM for a parametrised N-way set-associative, write-back, write-allocate cache. It sits between the CPU-side request interface and the physical-memory handshake, next to the cache datapath (tag/data/valid/dirty/PLRU arrays). Compared with the 2-way controller, it adds:

- tree pseudo-LRU replacement for any power-of-two way count;
- preference for invalid ways as victims;
- a registered victim that stays stable across writeback and fill;
- saturating hit/miss performance counters.

---
 rtl/cache_control_nway.sv | 180 ++++++++++++++++++
 tb/tb_cache_control_nway.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_control_nway.sv
// Control FSM for an N-way set-associative write-back, write-allocate cache.
// Handles hits, tree-PLRU victim choice, writeback/fill sequencing and hit/miss counters.
module cache_control_nway #(
  parameter int WAYS  = 4,
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cache_read,
  input  logic                    cache_write,
  input  logic [WAYS-1:0]         hit_vec,
  input  logic [WAYS-1:0]         valid_vec,
  input  logic [WAYS-1:0]         dirty_vec,
  input  logic [WAYS-2:0]         plru_in,
  input  logic                    mem_resp,
  input  logic                    cnt_clr,
  output logic                    cache_resp,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    mem_done,
  output logic                    rw_sel,
  output logic                    wb_sel,
  output logic [$clog2(WAYS)-1:0] way_sel,
  output logic [WAYS-1:0]         load_data,
  output logic [WAYS-1:0]         load_dirty,
  output logic [WAYS-1:0]         load_valid,
  output logic                    dirty_in,
  output logic                    load_plru,
  output logic [WAYS-2:0]         plru_out,
  output logic [CNT_W-1:0]        hit_count,
  output logic [CNT_W-1:0]        miss_count
);
  localparam int WW = $clog2(WAYS);

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_WB_GAP, S_FILL} state_t;

  state_t           r_state, w_state_next;
  logic [WW-1:0]    r_victim;
  logic             r_miss_pending;
  logic [CNT_W-1:0] r_hit_count, r_miss_count;

  logic             w_req, w_any_hit, w_has_invalid;
  logic             w_hit_done, w_miss_start;
  logic [WAYS-1:0]  w_hit_1h, w_inv_1h;
  logic [WW-1:0]    w_hit_way, w_inv_way, w_plru_way, w_victim_sel;
  logic [WAYS-2:0]  w_plru_upd;

  assign w_req         = cache_read | cache_write;
  assign w_any_hit     = |hit_vec;
  assign w_has_invalid = ~&valid_vec;

  // Isolate the lowest set hit bit and the lowest clear valid bit, then encode both.
  assign w_hit_1h = hit_vec & (~hit_vec + WAYS'(1));
  assign w_inv_1h = ~valid_vec & (valid_vec + WAYS'(1));

  genvar gi, gj;
  for (gi = 0; gi < WW; gi++) begin : g_enc
    logic [WAYS-1:0] w_mask;
    for (gj = 0; gj < WAYS; gj++) begin : g_mask
      assign w_mask[gj] = 1'((gj >> gi) & 1);
    end
    assign w_hit_way[gi] = |(w_hit_1h & w_mask);
    assign w_inv_way[gi] = |(w_inv_1h & w_mask);
  end

  // Victim walk: each level's bits select a node on the next level; the prefix becomes the way.
  for (gi = 0; gi < WW; gi++) begin : g_walk
    logic [gi:0] w_pfx;
    if (gi == 0) begin : g_root
      assign w_pfx = plru_in[0];
    end else begin : g_lvl
      logic [2**gi-1:0] w_lvl;
      assign w_lvl = plru_in[2**gi-1 +: 2**gi];
      assign w_pfx = {g_walk[gi-1].w_pfx, w_lvl[g_walk[gi-1].w_pfx]};
    end
  end
  assign w_plru_way = g_walk[WW-1].w_pfx;

  // Node gi sits at depth D, position P; it is on the hit path when the way's top D bits equal P.
  for (gi = 0; gi < WAYS-1; gi++) begin : g_upd
    localparam int D = $clog2(gi + 2) - 1;
    localparam int P = gi - (2**D - 1);
    logic w_on_path;
    assign w_on_path     = (int'(w_hit_way) >> (WW - D)) == P;
    assign w_plru_upd[gi] = w_on_path ? ~w_hit_way[WW-1-D] : plru_in[gi];
  end

  assign w_victim_sel = w_has_invalid ? w_inv_way : w_plru_way;

  always_comb begin
    w_state_next = r_state;
    w_hit_done   = 1'b0;
    w_miss_start = 1'b0;
    cache_resp   = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_done     = 1'b0;
    rw_sel       = 1'b0;
    wb_sel       = 1'b0;
    way_sel      = '0;
    load_data    = '0;
    load_dirty   = '0;
    load_valid   = '0;
    dirty_in     = 1'b0;
    load_plru    = 1'b0;
    plru_out     = '0;
    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          if (w_req && w_any_hit) begin
            w_hit_done = 1'b1;
            cache_resp = 1'b1;
            load_plru  = 1'b1;
            plru_out   = w_plru_upd;
            way_sel    = w_hit_way;
            if (cache_write) begin
              rw_sel     = 1'b1;
              load_data  = WAYS'(1) << w_hit_way;
              load_dirty = WAYS'(1) << w_hit_way;
              dirty_in   = 1'b1;
            end
          end else if (w_req) begin
            w_miss_start = 1'b1;
            w_state_next = dirty_vec[w_victim_sel] ? S_WRITEBACK : S_FILL;
          end
        end
        S_WRITEBACK: begin
          mem_write = 1'b1;
          wb_sel    = 1'b1;
          way_sel   = r_victim;
          if (mem_resp) w_state_next = S_WB_GAP;
        end
        S_WB_GAP: begin
          mem_done     = 1'b1;
          way_sel      = r_victim;
          w_state_next = S_FILL;
        end
        S_FILL: begin
          mem_read = 1'b1;
          way_sel  = r_victim;
          if (mem_resp) begin
            load_data    = WAYS'(1) << r_victim;
            load_dirty   = WAYS'(1) << r_victim;
            load_valid   = WAYS'(1) << r_victim;
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_victim       <= '0;
      r_miss_pending <= 1'b0;
      r_hit_count    <= '0;
      r_miss_count   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_miss_start) begin
        r_victim       <= w_victim_sel;
        r_miss_pending <= 1'b1;
      end else if (w_hit_done) begin
        r_miss_pending <= 1'b0;
      end
      // A hit that retires a pending miss was already counted as that miss.
      if (cnt_clr) r_hit_count <= '0;
      else if (w_hit_done && !r_miss_pending && !(&r_hit_count))
        r_hit_count <= r_hit_count + CNT_W'(1);
      if (cnt_clr) r_miss_count <= '0;
      else if (w_miss_start && !(&r_miss_count))
        r_miss_count <= r_miss_count + CNT_W'(1);
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
endmodule

// File: tb/tb_cache_control_nway.sv
// Bench for cache_control_nway: directed scenarios plus random traffic, all checked
// every cycle against a behavioural model built from the replacement and sequencing rules.
module tb_cache_control_nway;
  localparam int WAYS  = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int P_IDLE = 0, P_WB = 1, P_GAP = 2, P_FILL = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cache_read = 1'b0, cache_write = 1'b0;
  logic [WAYS-1:0]  hit_vec = '0, valid_vec = '0, dirty_vec = '0;
  logic [WAYS-2:0]  plru_in = '0;
  logic             mem_resp = 1'b0, cnt_clr = 1'b0;
  logic             cache_resp, mem_read, mem_write, mem_done, rw_sel, wb_sel;
  logic [1:0]       way_sel;
  logic [WAYS-1:0]  load_data, load_dirty, load_valid;
  logic             dirty_in, load_plru;
  logic [WAYS-2:0]  plru_out;
  logic [CNT_W-1:0] hit_count, miss_count;

  always #5 clk = ~clk;

  cache_control_nway #(.WAYS(WAYS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cache_read(cache_read), .cache_write(cache_write),
    .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .plru_in(plru_in),
    .mem_resp(mem_resp), .cnt_clr(cnt_clr), .cache_resp(cache_resp), .mem_read(mem_read),
    .mem_write(mem_write), .mem_done(mem_done), .rw_sel(rw_sel), .wb_sel(wb_sel),
    .way_sel(way_sel), .load_data(load_data), .load_dirty(load_dirty),
    .load_valid(load_valid), .dirty_in(dirty_in), .load_plru(load_plru),
    .plru_out(plru_out), .hit_count(hit_count), .miss_count(miss_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: which half of tree node n contains way w (0 none, 1 left, 2 right).
  function automatic int side_of(int n, int w);
    int d = 0;
    int p, span, lo;
    while (((1 << (d + 1)) - 1) <= n) d++;
    p    = n - ((1 << d) - 1);
    span = WAYS >> d;
    lo   = p * span;
    if (w >= lo && w < lo + span / 2) return 1;
    if (w >= lo + span / 2 && w < lo + span) return 2;
    return 0;
  endfunction

  function automatic logic [WAYS-2:0] m_plru_upd(logic [WAYS-2:0] pin, int h);
    logic [WAYS-2:0] r = pin;
    for (int n = 0; n < WAYS - 1; n++) begin
      if (side_of(n, h) == 1) r[n] = 1'b1;
      if (side_of(n, h) == 2) r[n] = 1'b0;
    end
    return r;
  endfunction

  // The PLRU victim is the unique way that every covering node points toward.
  function automatic int m_victim(logic [WAYS-1:0] valid, logic [WAYS-2:0] pin);
    for (int w = 0; w < WAYS; w++) if (!valid[w]) return w;
    for (int w = 0; w < WAYS; w++) begin
      bit ok = 1;
      for (int n = 0; n < WAYS - 1; n++) begin
        if (side_of(n, w) == 1 && pin[n] != 1'b0) ok = 0;
        if (side_of(n, w) == 2 && pin[n] != 1'b1) ok = 0;
      end
      if (ok) return w;
    end
    return 0;
  endfunction

  function automatic int lowest(logic [WAYS-1:0] v);
    for (int w = 0; w < WAYS; w++) if (v[w]) return w;
    return -1;
  endfunction

  function automatic int sat(int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  int m_ph = P_IDLE, m_v = 0, m_hit = 0, m_miss = 0;
  bit m_mp = 0;

  always @(negedge clk) begin
    int h, ph;
    bit req, way_care;
    logic e_resp, e_mrd, e_mwr, e_mdone, e_rw, e_wb, e_din, e_lp;
    logic [1:0] e_way;
    logic [WAYS-1:0] e_ld, e_ldd, e_ldv;
    logic [WAYS-2:0] e_po;
    e_resp = 0; e_mrd = 0; e_mwr = 0; e_mdone = 0; e_rw = 0; e_wb = 0; e_din = 0; e_lp = 0;
    e_way = '0; e_ld = '0; e_ldd = '0; e_ldv = '0; e_po = '0; way_care = 1;
    req = cache_read | cache_write;
    h = lowest(hit_vec);
    if ($countones(hit_vec) > 1) $display("illegal multi-hit hit_vec=%b", hit_vec);
    if (!rst_n) begin
      m_ph = P_IDLE; m_v = 0; m_mp = 0; m_hit = 0; m_miss = 0;
    end else begin
      case (m_ph)
        P_IDLE: if (req && h >= 0) begin
          e_resp = 1; e_lp = 1; e_way = 2'(h); e_po = m_plru_upd(plru_in, h);
          if (cache_write) begin
            e_rw = 1; e_din = 1; e_ld = WAYS'(1 << h); e_ldd = WAYS'(1 << h);
          end
        end
        P_WB: begin e_mwr = 1; e_wb = 1; e_way = 2'(m_v); end
        P_GAP: begin e_mdone = 1; way_care = 0; end
        default: begin
          e_mrd = 1; e_way = 2'(m_v);
          if (mem_resp) begin
            e_ld = WAYS'(1 << m_v); e_ldd = WAYS'(1 << m_v); e_ldv = WAYS'(1 << m_v);
          end
        end
      endcase
    end
    chk("cache_resp", cache_resp, e_resp);
    chk("mem_read", mem_read, e_mrd);
    chk("mem_write", mem_write, e_mwr);
    chk("mem_done", mem_done, e_mdone);
    chk("rw_sel", rw_sel, e_rw);
    chk("wb_sel", wb_sel, e_wb);
    if (way_care) chk("way_sel", way_sel, e_way);
    chk("load_data", load_data, e_ld);
    chk("load_dirty", load_dirty, e_ldd);
    chk("load_valid", load_valid, e_ldv);
    chk("dirty_in", dirty_in, e_din);
    chk("load_plru", load_plru, e_lp);
    chk("plru_out", plru_out, e_po);
    chk("hit_count", hit_count, m_hit);
    chk("miss_count", miss_count, m_miss);
    if (rst_n) begin
      int nh, nm;
      nh = m_hit; nm = m_miss; ph = m_ph;
      case (ph)
        P_IDLE: if (req) begin
          if (h >= 0) begin
            if (m_mp) m_mp = 0; else nh = sat(m_hit);
          end else begin
            m_v = m_victim(valid_vec, plru_in);
            m_mp = 1;
            nm = sat(m_miss);
            m_ph = dirty_vec[m_v] ? P_WB : P_FILL;
          end
        end
        P_WB: if (mem_resp) m_ph = P_GAP;
        P_GAP: m_ph = P_FILL;
        default: if (mem_resp) m_ph = P_IDLE;
      endcase
      if (cnt_clr) begin nh = 0; nm = 0; end
      m_hit = nh; m_miss = nm;
    end
  end

  task automatic at_neg;
    @(negedge clk); #1;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs;
    cache_read = 0; cache_write = 0; hit_vec = '0; mem_resp = 0; cnt_clr = 0;
  endtask

  initial begin
    at_neg;
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    tick;
    rst_n = 1;

    // Clean read miss, all ways valid, PLRU points at way 0.
    valid_vec = 4'hF; dirty_vec = '0; plru_in = 3'b000; cache_read = 1;
    at_neg; chk("t1_miss_no_resp", cache_resp, 0); tick;
    at_neg; chk("t1_fill_mem_read", mem_read, 1); chk("t1_fill_way", way_sel, 0); tick;
    mem_resp = 1;
    at_neg; chk("t1_load_data", load_data, 4'b0001); chk("t1_load_valid", load_valid, 4'b0001); tick;
    mem_resp = 0; hit_vec = 4'b0001;
    at_neg; chk("t1_hit_resp", cache_resp, 1); chk("t1_plru_out", plru_out, 3'b011); tick;
    idle_inputs;
    at_neg; chk("t1_miss_count", miss_count, 1); chk("t1_hit_count", hit_count, 0); tick;

    // Write hit on way 2.
    cache_write = 1; hit_vec = 4'b0100; plru_in = 3'b101;
    at_neg;
    chk("t2_resp", cache_resp, 1); chk("t2_load_data", load_data, 4'b0100);
    chk("t2_dirty_in", dirty_in, 1); chk("t2_rw_sel", rw_sel, 1);
    chk("t2_plru_bit0", plru_out[0], 0); chk("t2_plru_bit2", plru_out[2], 1);
    tick;
    idle_inputs;
    at_neg; chk("t2_hit_count", hit_count, 1); tick;

    // Dirty victim (way 2 via PLRU); array inputs wander during the miss.
    plru_in = 3'b011; dirty_vec = 4'b0100; valid_vec = 4'hF; cache_read = 1;
    at_neg; chk("t3_miss_no_write", mem_write, 0); tick;
    for (int i = 0; i < 5; i++) begin
      mem_resp = (i == 4);
      hit_vec = ($urandom_range(0, 1) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
      valid_vec = 4'($urandom); plru_in = 3'($urandom); dirty_vec = 4'($urandom);
      at_neg;
      chk("t3_wb_mem_write", mem_write, 1); chk("t3_wb_sel", wb_sel, 1); chk("t3_wb_way", way_sel, 2);
      tick;
    end
    mem_resp = 0; hit_vec = '0;
    at_neg; chk("t3_gap_done", mem_done, 1); chk("t3_gap_no_write", mem_write, 0); tick;
    at_neg; chk("t3_fill_read", mem_read, 1); chk("t3_fill_way", way_sel, 2); tick;
    mem_resp = 1;
    at_neg; chk("t3_fill_load", load_data, 4'b0100); chk("t3_fill_dirty", load_dirty, 4'b0100); tick;
    mem_resp = 0; hit_vec = 4'b0100;
    at_neg; chk("t3_hit_resp", cache_resp, 1); chk("t3_hit_way", way_sel, 2); tick;
    idle_inputs;
    at_neg; chk("t3_miss_count", miss_count, 2); chk("t3_hit_count", hit_count, 1); tick;

    // Invalid way 2 preferred over PLRU way 0.
    valid_vec = 4'b1011; plru_in = 3'b000; dirty_vec = '0; cache_read = 1;
    tick;
    at_neg; chk("t4_victim_way", way_sel, 2); tick;
    mem_resp = 1; tick;
    mem_resp = 0; hit_vec = 4'b0100; valid_vec = 4'hF;
    at_neg; chk("t4_hit_resp", cache_resp, 1); tick;
    idle_inputs;

    // Saturate the hit counter, then clear it together with a hit.
    for (int i = 0; i < 20; i++) begin
      cache_read = 1; cache_write = 1'($urandom); hit_vec = 4'(1 << $urandom_range(0, 3));
      tick;
    end
    idle_inputs;
    at_neg; chk("t5_hit_sat", hit_count, 4'hF); tick;
    cache_read = 1; hit_vec = 4'b0010; cnt_clr = 1; tick;
    idle_inputs;
    at_neg; chk("t5_clr_hit", hit_count, 0); chk("t5_clr_miss", miss_count, 0); tick;

    // Reset asserted mid-FILL (victim way 3).
    plru_in = 3'b111; valid_vec = 4'hF; dirty_vec = '0; cache_read = 1;
    tick;
    cache_read = 0;
    at_neg; chk("t6_fill_read", mem_read, 1); chk("t6_fill_way", way_sel, 3);
    #2 rst_n = 0;
    #1 chk("t6_rst_read", mem_read, 0); chk("t6_rst_way", way_sel, 0);
    tick; tick;
    rst_n = 1;
    at_neg; chk("t6_post_miss", miss_count, 0); chk("t6_post_idle", mem_read, 0); tick;
    cache_read = 1; hit_vec = 4'b0010;
    at_neg; chk("t6_idle_hit", cache_resp, 1); tick;
    idle_inputs;
    at_neg; chk("t6_hit_count", hit_count, 1); tick;

    // Random traffic checked by the per-cycle model.
    for (int c = 0; c < 3000; c++) begin
      cache_read  = ($urandom_range(0, 3) != 0);
      cache_write = ($urandom_range(0, 2) == 0);
      hit_vec   = ($urandom_range(0, 1) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
      valid_vec = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      dirty_vec = 4'($urandom);
      plru_in   = 3'($urandom);
      mem_resp  = ($urandom_range(0, 2) == 0);
      cnt_clr   = ($urandom_range(0, 63) == 0);
      tick;
    end
    idle_inputs;
    at_neg;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
